// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the core: base opcodes, ALU operation codes, and the
//   state/owner encodings used by the shared-memory arbiter.
//   No ports (package).
package mem_arbiter_pkg;

  // Base integer opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  // Requester identities; also the bit index into the arbiter request vector
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_IF) ? OWNER_LS : OWNER_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant. A lone request always wins; on a tie the
//   requester that did not win last time is granted.
//   Ports:
//     req        [1:0] request vector, bit 0 = IF, bit 1 = LS
//     last_grant       owner granted most recently
//     gnt        [1:0] one-hot grant (all zero when nothing requests)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (other_owner(last_grant) == OWNER_IF) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the fetch (IF) and load/store (LS)
//   units with exactly one transaction in flight. Grants are round-robin,
//   request fields are captured at the handshake and replayed to memory,
//   and a stalled transaction is abandoned with an error response after
//   TIMEOUT cycles.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     if_req_* / if_addr        fetch read request (valid/ready)
//     if_rsp_valid / if_rdata   fetch response pulse and held read data
//     ls_req_* / ls_addr / ls_wen / ls_wdata / ls_wmask
//                               load/store request (valid/ready)
//     ls_rsp_valid / ls_rdata   load/store response pulse and held data
//     rsp_err                   timeout flag, valid with either rsp pulse
//     mem_req_* / mem_addr / mem_wen / mem_wdata / mem_wmask
//                               request to the shared memory port
//     mem_rsp_valid / mem_rdata memory response
//   TIMEOUT must be at least 2.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // The counter reads 0 in the first cycle after the grant and the error
  // response is registered, so firing at TIMEOUT-2 puts the error pulse
  // exactly TIMEOUT cycles after the grant cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic                ls_rsp_valid_q, ls_rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic [1:0]          arb_req;
  logic [1:0]          arb_gnt;
  logic                timeout_hit;
  logic                deliver;
  logic                deliver_err;
  logic [DATA_W-1:0]   deliver_data;

  // Requests are only offered to the arbiter when the port is free, so the
  // grant vector doubles as the ready outputs.
  assign arb_req = (state_q == ARB_IDLE && !rst) ? {ls_req_valid, if_req_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req        (arb_req),
    .last_grant (last_q),
    .gnt        (arb_gnt)
  );

  assign timeout_hit = (cnt_q == CNT_LAST);

  assign if_req_ready  = arb_gnt[0];
  assign ls_req_ready  = arb_gnt[1];
  // Reset masks the strobes immediately rather than one edge later
  assign mem_req_valid = (state_q == ARB_REQ) && !rst;
  assign if_rsp_valid  = if_rsp_valid_q && !rst;
  assign ls_rsp_valid  = ls_rsp_valid_q && !rst;
  assign rsp_err       = rsp_err_q && !rst;
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    cnt_d          = cnt_q;
    if_rsp_valid_d = 1'b0;
    ls_rsp_valid_d = 1'b0;
    rsp_err_d      = 1'b0;
    if_rdata_d     = if_rdata_q;
    ls_rdata_d     = ls_rdata_q;
    deliver        = 1'b0;
    deliver_err    = 1'b0;
    deliver_data   = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (arb_gnt[0]) begin
          owner_d = OWNER_IF;
          last_d  = OWNER_IF;
          addr_d  = if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          cnt_d   = '0;
          state_d = ARB_REQ;
        end else if (arb_gnt[1]) begin
          owner_d = OWNER_LS;
          last_d  = OWNER_LS;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          cnt_d   = '0;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // A response before memory accepted the request cannot be ours
        if (timeout_hit) begin
          deliver     = 1'b1;
          deliver_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mem_req_ready) begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        // A real response wins over a timeout landing in the same cycle
        if (mem_rsp_valid) begin
          deliver      = 1'b1;
          deliver_data = mem_rdata;
        end else if (timeout_hit) begin
          deliver     = 1'b1;
          deliver_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (deliver) begin
      state_d   = ARB_IDLE;
      rsp_err_d = deliver_err;
      if (owner_q == OWNER_IF) begin
        if_rsp_valid_d = 1'b1;
        if_rdata_d     = deliver_data;
      end else begin
        ls_rsp_valid_d = 1'b1;
        ls_rdata_d     = deliver_data;
      end
    end
  end

  // Reset leaves LS as the last winner so IF takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWNER_IF;
      last_q         <= OWNER_LS;
      addr_q         <= '0;
      wen_q          <= 1'b0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      cnt_q          <= '0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      if_rdata_q     <= '0;
      ls_rdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      addr_q         <= addr_d;
      wen_q          <= wen_d;
      wdata_q        <= wdata_d;
      wmask_q        <= wmask_d;
      cnt_q          <= cnt_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      if_rdata_q     <= if_rdata_d;
      ls_rdata_q     <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   transaction-level model of the arbiter kept in this bench.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = DATA_W / 8;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_rsp_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              rsp_err;
  logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int passes = 0;

  // Transaction-level model: is a transaction in flight, has memory taken it,
  // how many cycles since its grant, and what response is due next cycle.
  bit                m_busy = 0, m_accepted = 0, m_owner_ls = 0, m_last_ls = 1;
  int                m_age = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_wen = 1'b0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [MASK_W-1:0] m_wmask = '0;
  bit                m_pulse_if = 0, m_pulse_ls = 0, m_err = 0;
  logic [DATA_W-1:0] m_rdata_if = '0, m_rdata_ls = '0;
  bit                hs_if = 0, hs_ls = 0;
  int unsigned       p_req, p_rdy, p_rsp;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      passes++;
  endtask

  task automatic finishTxn(input logic [DATA_W-1:0] data, input bit err);
    m_busy = 0;
    m_err  = err;
    if (m_owner_ls) begin
      m_pulse_ls = 1;
      m_rdata_ls = data;
    end else begin
      m_pulse_if = 1;
      m_rdata_if = data;
    end
  endtask

  // Called just after inputs are driven at the falling edge: checks this
  // cycle's outputs, then advances the model across the next rising edge.
  task automatic evalCycle();
    bit e_if_rdy, e_ls_rdy, e_mem_v;
    #1;
    e_if_rdy = !rst && !m_busy && if_req_valid && (!ls_req_valid || m_last_ls);
    e_ls_rdy = !rst && !m_busy && ls_req_valid && (!if_req_valid || !m_last_ls);
    e_mem_v  = !rst && m_busy && !m_accepted;
    checkOutput("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
    checkOutput("ls_req_ready", 64'(ls_req_ready), 64'(e_ls_rdy));
    checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(e_mem_v));
    checkOutput("if_rsp_valid", 64'(if_rsp_valid), 64'(!rst && m_pulse_if));
    checkOutput("ls_rsp_valid", 64'(ls_rsp_valid), 64'(!rst && m_pulse_ls));
    if (!rst && (m_pulse_if || m_pulse_ls))
      checkOutput("rsp_err", 64'(rsp_err), 64'(m_err));
    checkOutput("if_rdata", 64'(if_rdata), 64'(m_rdata_if));
    checkOutput("ls_rdata", 64'(ls_rdata), 64'(m_rdata_ls));
    if (e_mem_v) begin
      checkOutput("mem_addr", 64'(mem_addr), 64'(m_addr));
      checkOutput("mem_wen", 64'(mem_wen), 64'(m_wen));
      checkOutput("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      checkOutput("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
    end

    hs_if = e_if_rdy;
    hs_ls = e_ls_rdy;
    m_pulse_if = 0;
    m_pulse_ls = 0;
    m_err = 0;
    if (rst) begin
      m_busy = 0;
      m_accepted = 0;
      m_last_ls = 1;
      m_rdata_if = '0;
      m_rdata_ls = '0;
    end else if (m_busy) begin
      if (m_accepted && mem_rsp_valid) finishTxn(mem_rdata, 0);
      else if (m_age == TIMEOUT - 1) finishTxn('0, 1);
      else begin
        if (mem_req_ready) m_accepted = 1;
        m_age++;
      end
    end else if (e_if_rdy || e_ls_rdy) begin
      m_busy = 1;
      m_accepted = 0;
      m_age = 1;
      m_owner_ls = e_ls_rdy;
      m_last_ls = e_ls_rdy;
      if (e_ls_rdy) begin
        m_addr = ls_addr; m_wen = ls_wen; m_wdata = ls_wdata; m_wmask = ls_wmask;
      end else begin
        m_addr = if_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
      end
    end
  endtask

  // Requesters hold valid and fields until accepted; memory behaves randomly
  task automatic applyStimulus();
    rst = ($urandom_range(0, 249) == 0);
    if (!if_req_valid || hs_if) begin
      if_req_valid = ($urandom_range(0, 99) < p_req);
      if_addr = $urandom;
    end
    if (!ls_req_valid || hs_ls) begin
      ls_req_valid = ($urandom_range(0, 99) < p_req);
      ls_addr  = $urandom;
      ls_wen   = 1'($urandom_range(0, 1));
      ls_wdata = $urandom;
      ls_wmask = MASK_W'($urandom_range(0, 15));
    end
    mem_req_ready = ($urandom_range(0, 99) < p_rdy);
    mem_rsp_valid = ($urandom_range(0, 99) < p_rsp);
    mem_rdata = $urandom;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 0; if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
      evalCycle();
    end
  endtask

  task automatic zeroWaitIfRead(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                output int lat);
    @(negedge clk);
    if_req_valid = 1; if_addr = addr;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = data;
    evalCycle();
    checkOutput("ifrd_accept", 64'(if_req_ready), 64'(1));
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (hs_if) if_req_valid = 0;
      evalCycle();
      if (c == 1) begin
        checkOutput("ifrd_mem_addr", 64'(mem_addr), 64'(addr));
        checkOutput("ifrd_mem_wen", 64'(mem_wen), 64'(0));
        checkOutput("ifrd_mem_wmask", 64'(mem_wmask), 64'(0));
      end
      if (if_rsp_valid && lat == 0) begin
        lat = c;
        checkOutput("ifrd_rdata", 64'(if_rdata), 64'(data));
        checkOutput("ifrd_err", 64'(rsp_err), 64'(0));
      end
    end
    mem_rsp_valid = 0;
  endtask

  initial begin
    int lat, ls_at, both, pulses, stray, to_at, if_acc;
    rst = 1;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    @(posedge clk);

    // Reset: readies masked even with both requesters valid, fields cleared
    @(negedge clk);
    if_req_valid = 1; ls_req_valid = 1; mem_rsp_valid = 1;
    evalCycle();
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    checkOutput("rst_mem_wmask", 64'(mem_wmask), 64'(0));
    checkOutput("rst_mem_wen", 64'(mem_wen), 64'(0));
    idleCycles(2);

    // IF-only zero-wait read
    zeroWaitIfRead(32'h8000_0000, 32'h0000_0413, lat);
    checkOutput("d38_latency", 64'(lat), 64'(3));
    idleCycles(2);

    // Both valid right after reset: IF first, LS on the next free cycle
    @(negedge clk); rst = 1; evalCycle();
    @(negedge clk); evalCycle();
    @(negedge clk);
    rst = 0;
    if_req_valid = 1; if_addr = 32'h0000_0100;
    ls_req_valid = 1; ls_addr = 32'h0000_0200; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
    evalCycle();
    checkOutput("d39_if_first", 64'(if_req_ready), 64'(1));
    checkOutput("d39_ls_waits", 64'(ls_req_ready), 64'(0));
    ls_at = -1; both = 0; if_acc = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (hs_if) begin
        if_acc++;
        if_req_valid = (if_acc <= 2);
        if_addr = if_addr + 32'd4;
      end
      if (hs_ls) ls_req_valid = 0;
      evalCycle();
      if (if_req_ready && ls_req_ready) both++;
      if (ls_req_ready && ls_at < 0) ls_at = c;
    end
    checkOutput("d39_ls_grant_cycle", 64'(ls_at), 64'(3));
    checkOutput("d39_both_ready", 64'(both), 64'(0));
    idleCycles(2);

    // LS store with memory stalling; stray response while not yet accepted
    @(negedge clk);
    ls_req_valid = 1; ls_addr = 32'h8000_1000; ls_wen = 1;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'h3;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 32'h0000_0055;
    evalCycle();
    checkOutput("d40_accept", 64'(ls_req_ready), 64'(1));
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (hs_ls) begin
        ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
      end
      mem_req_ready = (c == 4);
      mem_rsp_valid = (c == 2 || c == 5);
      evalCycle();
      if (c <= 4) begin
        checkOutput("d40_mem_valid", 64'(mem_req_valid), 64'(1));
        checkOutput("d40_mem_addr", 64'(mem_addr), 64'h8000_1000);
        checkOutput("d40_mem_wen", 64'(mem_wen), 64'(1));
        checkOutput("d40_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        checkOutput("d40_mem_wmask", 64'(mem_wmask), 64'h3);
      end
      if (ls_rsp_valid) begin
        pulses++;
        checkOutput("d40_rdata", 64'(ls_rdata), 64'h55);
      end
    end
    checkOutput("d40_pulses", 64'(pulses), 64'(1));
    idleCycles(2);

    // Memory accepts but never answers: error after TIMEOUT, late reply dropped
    @(negedge clk);
    if_req_valid = 1; if_addr = 32'h8000_0040;
    mem_req_ready = 1; mem_rsp_valid = 0; mem_rdata = 32'h0000_0413;
    evalCycle();
    to_at = 0; stray = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (hs_if) if_req_valid = 0;
      mem_rsp_valid = (c >= 9);
      evalCycle();
      if (if_rsp_valid || ls_rsp_valid) begin
        if (c <= 8 && to_at == 0) begin
          to_at = c;
          checkOutput("d41_err", 64'(rsp_err), 64'(1));
          checkOutput("d41_rdata", 64'(if_rdata), 64'(0));
        end else stray++;
      end
    end
    checkOutput("d41_timeout_cycle", 64'(to_at), 64'(TIMEOUT));
    checkOutput("d41_stray", 64'(stray), 64'(0));
    idleCycles(2);

    // Reset while waiting for memory, then a late response
    @(negedge clk);
    if_req_valid = 1; if_addr = 32'h8000_0080;
    mem_req_ready = 1; mem_rsp_valid = 0; mem_rdata = 32'h0000_1234;
    evalCycle();
    @(negedge clk); if_req_valid = 0; evalCycle();
    @(negedge clk); rst = 1; mem_req_ready = 0; evalCycle();
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = 0;
      mem_rsp_valid = (c == 0);
      evalCycle();
      if (if_rsp_valid || ls_rsp_valid) pulses++;
    end
    checkOutput("d42_no_pulse", 64'(pulses), 64'(0));
    checkOutput("d42_mem_idle", 64'(mem_req_valid), 64'(0));
    zeroWaitIfRead(32'h8000_00C0, 32'h0000_CAFE, lat);
    checkOutput("d42_latency", 64'(lat), 64'(3));
    idleCycles(2);

    // Randomized traffic under several memory behaviours
    for (int mode = 0; mode < 4; mode++) begin
      case (mode)
        0: begin p_req = 60; p_rdy = 100; p_rsp = 100; end
        1: begin p_req = 50; p_rdy = 50;  p_rsp = 50;  end
        2: begin p_req = 80; p_rdy = 30;  p_rsp = 20;  end
        default: begin p_req = 40; p_rdy = 60; p_rsp = 5; end
      endcase
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        applyStimulus();
        evalCycle();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set address width.
REQ-002 Parameter DATA_W, default 32, SHALL set data width; the write-mask width SHALL be DATA_W/8.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles a granted transaction may wait for memory.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_req_valid  in  1  fetch unit requests a read.
REQ-007 if_req_ready  out  1  fetch request accepted this cycle.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_rsp_valid  out  1  one-cycle pulse; fetch response present.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 ls_req_valid  in  1  load/store unit request.
REQ-012 ls_req_ready  out  1  load/store request accepted this cycle.
REQ-013 ls_addr  in  ADDR_W  load/store address.
REQ-014 ls_wen  in  1  1 = store, 0 = load.
REQ-015 ls_wdata  in  DATA_W  store data.
REQ-016 ls_wmask  in  DATA_W/8  store byte enables.
REQ-017 ls_rsp_valid  out  1  one-cycle pulse; load/store response present.
REQ-018 ls_rdata  out  DATA_W  load data.
REQ-019 rsp_err  out  1  timeout flag, qualified by whichever rsp_valid pulses.
REQ-020 mem_req_valid  out  1  request to shared memory port.
REQ-021 mem_req_ready  in  1  memory accepts request.
REQ-022 mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields.
REQ-023 mem_rsp_valid  in  1  memory response present.
REQ-024 mem_rdata  in  DATA_W  memory read data.

Function
REQ-025 FSM states: IDLE, REQ, WAIT; only one transaction SHALL be outstanding.
REQ-026 IDLE: the arbiter SHALL grant one valid requester; x_req_ready SHALL be combinational and high only in IDLE for the granted port; with both ports valid, the port not granted last SHALL win (round-robin).
REQ-027 On grant, the arbiter SHALL latch the owner, address, wen, wdata and wmask, and go to REQ; for an IF grant it SHALL force wen=0, wmask=0, wdata=0.
REQ-028 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready the FSM SHALL go to WAIT; mem_rsp_valid in REQ SHALL be ignored.
REQ-029 WAIT: on mem_rsp_valid, the arbiter SHALL register mem_rdata into the owner's rdata, pulse the owner's rsp_valid the next cycle with rsp_err=0, and return to IDLE.
REQ-030 Latency: the minimum request-accept to rsp_valid latency SHALL be 3 cycles with zero-wait memory; a new grant SHALL be allowed in the same cycle as the response pulse.
REQ-031 Timeout: a counter SHALL clear on grant and increment in REQ and WAIT; on reaching TIMEOUT, the FSM SHALL pulse the owner's rsp_valid with rsp_err=1 and rdata=0, deassert mem_req_valid, and return to IDLE.
REQ-032 A mem_rsp_valid arriving in IDLE (late, after timeout) SHALL be discarded with no response pulse.
REQ-033 The non-owner's rsp_valid SHALL never pulse; rdata outputs SHALL hold their last value between pulses.
REQ-034 The arbiter SHALL sample requester fields only at handshake; requesters hold valid and fields until ready.

Reset
REQ-035 While rst=1, all valid/ready outputs and rsp_err SHALL be 0, rdata and mem_* fields 0, state IDLE, counter 0, last-grant=LS (IF wins the first tie); a reset mid-transaction SHALL drop that transaction with no response.

Structure
REQ-036 FSM state encodings and owner codes (IF=0, LS=1) SHALL live in the shared TYPES package alongside the existing opcode and ALU constants.
REQ-037 The round-robin grant logic SHALL be one sub-module, rr_arb2 (two requests, last-grant input, one-hot grant output).

Verification
REQ-038 IF-only read of 0x80000000, memory returns 0x00000413 with zero wait -> if_rsp_valid pulses 3 cycles after accept, if_rdata=0x00000413, rsp_err=0.
REQ-039 Both valid on the first cycle after reset -> IF granted first, LS granted on the next IDLE cycle, no cycle with both readies high.
REQ-040 LS store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x3 -> mem_* shows exact fields held until mem_req_ready; ls_rsp_valid pulses once.
REQ-041 TIMEOUT=8, memory never responds -> owner rsp_valid with rsp_err=1 and rdata=0 exactly 8 cycles after grant; a later stray mem_rsp_valid produces no pulse.
REQ-042 rst asserted in WAIT, then memory responds -> no rsp_valid; state IDLE; the next IF request completes normally.
